irq_controller: RTL and testbench

- Interrupt controller directly upstream of the processor's control logic; drives the processor's IRQ input.
- Latches NUM_SRC external interrupt sources (edge- or level-type per source) and masks them.
- Presents a single registered IRQ request and performs a claim/EOI handshake with the processor.
- The processor's exception path (PC redirected to XAddr, old PC saved in XPReg) pulses IRQ_ACK; the handler reads the claimed source ID and signals EOI when done.

---
 rtl/irq_controller_pkg.sv | 17 +
 rtl/irq_controller_if.sv | 22 ++
 rtl/irq_controller_prio_encoder.sv | 23 ++
 rtl/irq_controller.sv | 143 ++++++++++++++
 tb/tb_irq_controller.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/irq_controller_pkg.sv
// Shared constants and state encoding for the interrupt controller.
package irq_controller_pkg;

   localparam logic [1:0] IRQ_REG_MASK  = 2'd0;
   localparam logic [1:0] IRQ_REG_PEND  = 2'd1;
   localparam logic [1:0] IRQ_REG_EDGE  = 2'd2;
   localparam logic [1:0] IRQ_REG_CLAIM = 2'd3;

   // Sliced down to ID_W at the point of use.
   localparam logic [31:0] IRQ_SPURIOUS_ID = '1;

   typedef enum logic {
      IRQ_ST_IDLE    = 1'b0,
      IRQ_ST_SERVICE = 1'b1
   } irq_state_e;

endpackage

// File: rtl/irq_controller_if.sv
// Processor-side IRQ handshake and register bus of the interrupt controller.
interface irq_controller_if #(
   parameter int DATA_W = 32
);
   logic              IRQ;
   logic              IRQ_ACK;
   logic              EOI;
   logic              REG_WE;
   logic [1:0]        REG_ADDR;
   logic [DATA_W-1:0] REG_WDATA;
   logic [DATA_W-1:0] REG_RDATA;

   modport slave (
      output IRQ, REG_RDATA,
      input  IRQ_ACK, EOI, REG_WE, REG_ADDR, REG_WDATA
   );

   modport master (
      input  IRQ, REG_RDATA,
      output IRQ_ACK, EOI, REG_WE, REG_ADDR, REG_WDATA
   );
endinterface

// File: rtl/irq_controller_prio_encoder.sv
// Lowest-index-first priority encoder over the eligible pending vector.
module irq_prio_encoder #(
   parameter int NUM_SRC = 8,
   parameter int ID_W    = 5
) (
   input  logic [NUM_SRC-1:0] req,
   output logic               valid,
   output logic [ID_W-1:0]    id
);

   always_comb begin
      valid = 1'b0;
      id    = '0;
      // Scan downward so the lowest set index is the last one written.
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            id    = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge/level source latching, masking, registered IRQ and claim/EOI.
// Optional IRQ_SYNC_EN adds a 2-flop synchronizer on every SRC bit.
module irq_controller
   import irq_controller_pkg::*;
#(
   parameter int NUM_SRC = 8,
   parameter int DATA_W  = 32,
   parameter int ID_W    = 5
) (
   input  logic               clk,
   input  logic               RESET_N,
   input  logic [NUM_SRC-1:0] SRC,
   irq_controller_if.slave    bus
);

   logic [NUM_SRC-1:0] src_s;

`ifdef IRQ_SYNC_EN
   logic [NUM_SRC-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= SRC;
         sync2_q <= sync1_q;
      end
   end

   assign src_s = sync2_q;
`else
   assign src_s = SRC;
`endif

   logic [NUM_SRC-1:0] mask_q, mask_d;
   logic [NUM_SRC-1:0] edge_q, edge_d;
   logic [NUM_SRC-1:0] pend_q, pend_d;
   logic [NUM_SRC-1:0] prev_q, prev_d;
   logic [ID_W-1:0]    claim_q, claim_d;
   irq_state_e         state_q, state_d;
   logic               irq_q, irq_d;

   logic [NUM_SRC-1:0] pending, eligible, rise, w1c, claim_clr;
   logic               prio_vld;
   logic [ID_W-1:0]    prio_id;
   logic [DATA_W-1:0]  rdata;
   logic               unused_wdata;

   // Level bits are live views of the source; only edge bits hold state.
   assign pending  = (edge_q & pend_q) | (~edge_q & src_s);
   assign eligible = pending & mask_q;
   assign rise     = src_s & ~prev_q;

   irq_prio_encoder #(
      .NUM_SRC (NUM_SRC),
      .ID_W    (ID_W)
   ) u_prio (
      .req   (eligible),
      .valid (prio_vld),
      .id    (prio_id)
   );

   always_comb begin
      mask_d    = mask_q;
      edge_d    = edge_q;
      state_d   = state_q;
      claim_d   = claim_q;
      prev_d    = src_s;
      w1c       = '0;
      claim_clr = '0;

      if (bus.REG_WE) begin
         case (bus.REG_ADDR)
            IRQ_REG_MASK: mask_d = bus.REG_WDATA[NUM_SRC-1:0];
            IRQ_REG_PEND: w1c    = bus.REG_WDATA[NUM_SRC-1:0];
            IRQ_REG_EDGE: edge_d = bus.REG_WDATA[NUM_SRC-1:0];
            default: ;
         endcase
      end

      case (state_q)
         IRQ_ST_IDLE: begin
            if (bus.IRQ_ACK) begin
               if (prio_vld) begin
                  claim_d   = prio_id;
                  claim_clr = NUM_SRC'(1) << prio_id;
                  state_d   = IRQ_ST_SERVICE;
               end else begin
                  claim_d = IRQ_SPURIOUS_ID[ID_W-1:0];
               end
            end
         end
         IRQ_ST_SERVICE: begin
            // EOI beats a coincident ACK; the ACK is simply not looked at here.
            if (bus.EOI) state_d = IRQ_ST_IDLE;
         end
         default: state_d = IRQ_ST_IDLE;
      endcase

      // Set wins over clear; masking with edge_q clears bits while level-type.
      pend_d = (rise | (pend_q & ~(w1c | claim_clr))) & edge_q;
      irq_d  = (|eligible) && (state_d == IRQ_ST_IDLE);
   end

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         mask_q  <= '0;
         edge_q  <= '0;
         pend_q  <= '0;
         prev_q  <= '0;
         claim_q <= IRQ_SPURIOUS_ID[ID_W-1:0];
         state_q <= IRQ_ST_IDLE;
         irq_q   <= 1'b0;
      end else begin
         mask_q  <= mask_d;
         edge_q  <= edge_d;
         pend_q  <= pend_d;
         prev_q  <= prev_d;
         claim_q <= claim_d;
         state_q <= state_d;
         irq_q   <= irq_d;
      end
   end

   always_comb begin
      rdata = '0;
      case (bus.REG_ADDR)
         IRQ_REG_MASK: rdata[NUM_SRC-1:0] = mask_q;
         IRQ_REG_PEND: rdata[NUM_SRC-1:0] = pending;
         IRQ_REG_EDGE: rdata[NUM_SRC-1:0] = edge_q;
         default: begin
            rdata[ID_W-1:0] = claim_q;
            rdata[ID_W]     = (state_q == IRQ_ST_SERVICE);
         end
      endcase
   end

   assign bus.REG_RDATA = rdata;
   assign bus.IRQ       = irq_q;
   assign unused_wdata  = ^bus.REG_WDATA;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: stimulus queues expectations, a negedge monitor checks them.
module tb_irq_controller;

   logic       clk = 1'b0;
   logic       RESET_N;
   logic [7:0] SRC;

   irq_controller_if #(.DATA_W(32)) bus_if ();

   irq_controller #(
      .NUM_SRC (8),
      .DATA_W  (32),
      .ID_W    (5)
   ) dut (
      .clk     (clk),
      .RESET_N (RESET_N),
      .SRC     (SRC),
      .bus     (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      bit          is_irq;
      logic [31:0] exp;
   } chk_t;

   chk_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Monitor: every expectation queued during a cycle is checked at that cycle's negedge.
   always @(negedge clk) begin
      chk_t        it;
      logic [31:0] act;
      while (sb.size() > 0) begin
         it  = sb.pop_front();
         act = it.is_irq ? {31'd0, bus_if.IRQ} : bus_if.REG_RDATA;
         checks++;
         if (act !== it.exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", it.name, act, it.exp);
         end
      end
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic push_reg(input string name, input logic [1:0] addr, input logic [31:0] exp);
      chk_t it;
      bus_if.REG_ADDR = addr;
      it.name   = name;
      it.is_irq = 1'b0;
      it.exp    = exp;
      sb.push_back(it);
   endtask

   task automatic push_irq(input string name, input logic exp);
      chk_t it;
      it.name   = name;
      it.is_irq = 1'b1;
      it.exp    = {31'd0, exp};
      sb.push_back(it);
   endtask

   task automatic wr(input logic [1:0] addr, input logic [31:0] data);
      bus_if.REG_WE    = 1'b1;
      bus_if.REG_ADDR  = addr;
      bus_if.REG_WDATA = data;
      cyc();
      bus_if.REG_WE    = 1'b0;
   endtask

   initial begin
      RESET_N          = 1'b0;
      SRC              = '0;
      bus_if.IRQ_ACK   = 1'b0;
      bus_if.EOI       = 1'b0;
      bus_if.REG_WE    = 1'b0;
      bus_if.REG_ADDR  = 2'd0;
      bus_if.REG_WDATA = '0;
      repeat (3) cyc();
      RESET_N = 1'b1;

      // Reset values
      push_reg("rst_mask", 2'd0, 32'h0); push_irq("rst_irq", 1'b0); cyc();
      push_reg("rst_pend", 2'd1, 32'h0); cyc();
      push_reg("rst_edge", 2'd2, 32'h0); cyc();
      push_reg("rst_claim", 2'd3, 32'h1F); cyc();

      // Edge sources 3 then 2, lowest index claimed first
      wr(2'd2, 32'hFF);
      wr(2'd0, 32'h0C);
      SRC = 8'h08; cyc();
      SRC = 8'h04; push_irq("edge_irq_up", 1'b1); cyc();
      SRC = 8'h00; push_reg("edge_pend_0c", 2'd1, 32'h0C); cyc();
      bus_if.IRQ_ACK = 1'b1;
      push_reg("ack_claim_2", 2'd3, 32'h22); push_irq("ack_irq_dn", 1'b0); cyc();
      bus_if.IRQ_ACK = 1'b0;
      push_reg("ack_pend_08", 2'd1, 32'h08); cyc();
      bus_if.EOI = 1'b1;
      push_irq("eoi_irq_up", 1'b1); push_reg("eoi_claim_kept", 2'd3, 32'h02); cyc();
      bus_if.EOI = 1'b0;
      bus_if.IRQ_ACK = 1'b1;
      push_reg("ack_claim_3", 2'd3, 32'h23); push_irq("ack2_irq_dn", 1'b0); cyc();
      bus_if.IRQ_ACK = 1'b0;
      bus_if.EOI = 1'b1;
      push_irq("eoi2_irq", 1'b0); push_reg("eoi2_claim", 2'd3, 32'h03); cyc();
      bus_if.EOI = 1'b0;

      // Level source 5 withdraws in the ACK cycle -> spurious
      wr(2'd2, 32'hDF);
      wr(2'd0, 32'h20);
      SRC = 8'h20;
      push_irq("lvl_irq_up", 1'b1); push_reg("lvl_pend", 2'd1, 32'h20); cyc();
      SRC = 8'h00; bus_if.IRQ_ACK = 1'b1;
      push_reg("spurious_claim", 2'd3, 32'h1F); push_irq("spurious_irq", 1'b0); cyc();
      bus_if.IRQ_ACK = 1'b0;

      // Edge arriving during SERVICE, then EOI+ACK together
      wr(2'd2, 32'hFF);
      wr(2'd0, 32'h03);
      SRC = 8'h01; cyc();
      SRC = 8'h00; cyc();
      bus_if.IRQ_ACK = 1'b1;
      push_reg("svc_claim_0", 2'd3, 32'h20); push_irq("svc_irq_dn", 1'b0); cyc();
      bus_if.IRQ_ACK = 1'b0;
      SRC = 8'h02; cyc();
      SRC = 8'h00;
      push_reg("svc_pend_latched", 2'd1, 32'h02); push_irq("svc_irq_held", 1'b0); cyc();
      bus_if.EOI = 1'b1; bus_if.IRQ_ACK = 1'b1;
      push_irq("eoi_ack_irq", 1'b1); push_reg("eoi_ack_claim", 2'd3, 32'h00); cyc();
      bus_if.EOI = 1'b0; bus_if.IRQ_ACK = 1'b0;
      push_reg("eoi_ack_pend", 2'd1, 32'h02); cyc();

      // Masking drops IRQ but keeps PENDING
      wr(2'd0, 32'h01);
      push_irq("mask_irq_dn", 1'b0); push_reg("mask_pend_kept", 2'd1, 32'h02); cyc();

      // W1C versus a simultaneous new edge
      wr(2'd1, 32'h02);
      SRC = 8'h01; cyc();
      SRC = 8'h00; push_reg("w1c_setup", 2'd1, 32'h01); cyc();
      SRC = 8'h01;
      bus_if.REG_WE = 1'b1; bus_if.REG_ADDR = 2'd1; bus_if.REG_WDATA = 32'h01;
      cyc();
      bus_if.REG_WE = 1'b0; SRC = 8'h00;
      push_reg("set_beats_w1c", 2'd1, 32'h01); cyc();
      wr(2'd1, 32'h01);
      push_reg("w1c_clears", 2'd1, 32'h00); cyc();

      // Reset asserted mid-service with another source pending
      wr(2'd0, 32'h03);
      SRC = 8'h02; cyc();
      SRC = 8'h00; cyc();
      bus_if.IRQ_ACK = 1'b1; cyc();
      bus_if.IRQ_ACK = 1'b0;
      SRC = 8'h01; cyc();
      SRC = 8'h00;
      push_reg("pre_rst_pend", 2'd1, 32'h01); cyc();
      push_reg("pre_rst_claim", 2'd3, 32'h21); cyc();
      @(posedge clk); #1;
      RESET_N = 1'b0;
      push_irq("async_rst_irq", 1'b0); push_reg("async_rst_pend", 2'd1, 32'h00);
      @(negedge clk); #1;
      push_reg("async_rst_claim", 2'd3, 32'h1F); cyc();
      RESET_N = 1'b1;

      for (int i = 0; i < 20 && sb.size() > 0; i++) cyc();
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
